// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, ALU ops,
// datapath mux selects and the control FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_I   = 3'b001;
  localparam logic [2:0] ALU_OP_LUI = 3'b010;
  localparam logic [2:0] ALU_OP_ADD = 3'b011;
  localparam logic [2:0] ALU_OP_SUB = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_LUI      = 4'd9,
    ST_ALUWB    = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JAL      = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry
// on the cycle the count would reach MEM_WAIT_MAX.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (!active || ready)
      count <= '0;
    else
      count <= count + 16'd1;
  end

  // ready in the same cycle suppresses expiry
  assign expired = active && !ready && (count == 16'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core: sequences instructions and
// decodes datapath controls from the state register.
// states: IDLE | FETCH (IR load) | DECODE | MEMADR | MEMREAD | MEMWB | MEMWRITE |
//   EXEC_R | EXEC_I | LUI | ALUWB (rd write) | BRANCH | JAL | TRAP (absorbing)
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        i_or_d_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  result_src_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic [3:0]  state_o
);

  state_t state, state_next;
  logic   mem_expired;
  logic   set_illegal;
  logic   set_timeout;
  logic   is_word;

  assign is_word = (funct3_i == F3_WORD);
  assign state_o = state;

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (mem_req_o),
    .ready   (mem_ready_i),
    .expired (mem_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready_i) state_next = ST_DECODE;
        else if (mem_expired) begin
          state_next  = ST_TRAP;
          set_timeout = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_next = is_word ? ST_MEMADR : ST_TRAP;
          OP_RTYPE:  state_next = ST_EXEC_R;
          OP_ITYPE:  state_next = ST_EXEC_I;
          OP_BRANCH: state_next = (funct3_i == F3_BEQ || funct3_i == F3_BNE) ? ST_BRANCH : ST_TRAP;
          OP_JAL:    state_next = ST_JAL;
          OP_LUI:    state_next = ST_LUI;
          default:   state_next = ST_TRAP;
        endcase
        set_illegal = (state_next == ST_TRAP);
      end
      ST_MEMADR: state_next = (opcode_i == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD, ST_MEMWRITE: begin
        if (mem_ready_i) state_next = (state == ST_MEMREAD) ? ST_MEMWB : ST_FETCH;
        else if (mem_expired) begin
          state_next  = ST_TRAP;
          set_timeout = 1'b1;
        end
      end
      ST_MEMWB, ST_ALUWB, ST_BRANCH: state_next = ST_FETCH;
      ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_JAL: state_next = ST_ALUWB;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    retire_o     = 1'b0;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_RS2;
    alu_op_o     = ALU_OP_R;
    result_src_o = RES_ALUOUT;
    case (state)
      ST_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_OP_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      ST_MEMADR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      ST_MEMREAD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MDR;
        retire_o     = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        retire_o    = mem_ready_i;
      end
      ST_EXEC_R: alu_src_a_o = SRC_A_RS1;
      ST_EXEC_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_I;
      end
      ST_LUI: begin
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_LUI;
      end
      ST_ALUWB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o = SRC_A_RS1;
        alu_op_o    = ALU_OP_SUB;
        pc_write_o  = (funct3_i == F3_BEQ && zero_i) || (funct3_i == F3_BNE && !zero_i);
        retire_o    = 1'b1;
      end
      ST_JAL: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_OP_ADD;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
      instret_o <= '0;
    end else begin
      if (set_illegal) illegal_o <= 1'b1;
      if (set_timeout) timeout_o <= 1'b1;
      if (retire_o) instret_o <= instret_o + 32'd1;
    end
  end

endmodule
